score_display: RTL and testbench



---
 rtl/score_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 86 ++++++++
 rtl/score_display.sv | 104 ++++++++++
 tb/tb_score_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants, segment table and converter state type for the score display path.
package score_pkg;

  localparam int unsigned SCORE_W    = 12;
  localparam int unsigned BCD_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_LUT[0];
      4'd1:    s = SEG_LUT[1];
      4'd2:    s = SEG_LUT[2];
      4'd3:    s = SEG_LUT[3];
      4'd4:    s = SEG_LUT[4];
      4'd5:    s = SEG_LUT[5];
      4'd6:    s = SEG_LUT[6];
      4'd7:    s = SEG_LUT[7];
      4'd8:    s = SEG_LUT[8];
      4'd9:    s = SEG_LUT[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: capture on start, BIN_W shift edges, then one publish edge.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned BIN_W  = score_pkg::SCORE_W,
  parameter int unsigned DIGITS = score_pkg::BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  conv_state_e          state_q, state_d;
  logic [BIN_W-1:0]     shreg_q, shreg_d;
  logic [4*DIGITS-1:0]  acc_q, acc_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [4*DIGITS-1:0]  adj;

  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      adj[k*4 +: 4] = (acc_q[k*4 +: 4] >= 4'd5) ? acc_q[k*4 +: 4] + 4'd3 : acc_q[k*4 +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign bcd   = bcd_q;
  assign valid = valid_q;

endmodule

// File: rtl/score_display.sv
// Score-to-7-segment path: change-triggered BCD conversion plus a multiplexed digit scanner.
module score_display
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W       = score_pkg::SCORE_W,
  parameter int unsigned DIGITS        = score_pkg::BCD_DIGITS,
  parameter int unsigned SCAN_DIV      = 100000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SCORE_W-1:0]   score,
  output logic [4*DIGITS-1:0]  bcd,
  output logic                 bcd_valid,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [DIGITS-1:0]    an
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCORE_W-1:0]  last_score_q, last_score_d;
  logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [DIGITS-1:0]   lead_zero;
  logic [3:0]          nib;
  logic                start, busy;
  logic [4*DIGITS-1:0] bcd_w;
  logic                valid_w;

  // Changes arriving mid-conversion are picked up once the converter is back in IDLE
  assign start = (score != last_score_q) && !busy;

  bin2bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .bin   (score),
    .start (start),
    .busy  (busy),
    .bcd   (bcd_w),
    .valid (valid_w)
  );

  always_comb begin
    last_score_d = start ? score : last_score_q;
    scan_cnt_d   = scan_cnt_q + 1'b1;
    idx_d        = idx_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // lead_zero[k]: nibbles k..DIGITS-1 are all zero
  always_comb begin
    logic          zero_run;
    int unsigned   k;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      k = DIGITS - 1 - j;
      zero_run = zero_run && (bcd_w[k*4 +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end

  always_comb begin
    nib  = bcd_w[{idx_q, 2'b00} +: 4];
    an_d = ~(DIGITS'(1) << idx_q);
    if ((BLANK_LEADING != 0) && (idx_q != '0) && lead_zero[idx_q])
      seg_d = SEG_BLANK;
    else
      seg_d = seg_decode(nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_score_q <= '0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      last_score_q <= last_score_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bcd       = bcd_w;
  assign bcd_valid = valid_w;
  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display with a short scan period.
module tb_score_display;

  logic        clk;
  logic        reset;
  logic [11:0] score;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  score_display #(
    .SCORE_W       (12),
    .DIGITS        (4),
    .SCAN_DIV      (4),
    .BLANK_LEADING (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bcd_valid === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset;
    reset = 1'b1;
    score = 12'd0;
    #22;
    reset = 1'b0;
    #1;
    n_cmp++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h want F", an); end
    n_cmp++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7F", seg); end
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
    n_cmp++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bcd_valid); end
    n_cmp++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    @(posedge clk); #1;
    n_cmp++; if (an !== 4'hE) begin n_fail++; $display("FAIL first_edge_an: got %h want E", an); end
    n_cmp++; if (seg !== 7'h40) begin n_fail++; $display("FAIL first_edge_seg: got %h want 40", seg); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL zero_no_pulse: got %0d want 0", pulses); end
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL zero_bcd: got %h want 0000", bcd); end
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    pulses = 0;
    score = 12'd1234;
    repeat (13) @(posedge clk);
    #1;
    n_cmp++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", bcd_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_e13: got %b want 1", bcd_valid); end
    n_cmp++; if (bcd !== 16'h1234) begin n_fail++; $display("FAIL single_bcd: got %h want 1234", bcd); end
    repeat (100) @(posedge clk);
    #1;
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
    n_cmp++; if (bcd !== 16'h1234) begin n_fail++; $display("FAIL single_bcd_hold: got %h want 1234", bcd); end
  endtask

  task automatic test_values;
    logic [11:0] vals [3];
    logic [15:0] exps [3];
    vals = '{12'd4095, 12'd9, 12'd100};
    exps = '{16'h4095, 16'h0009, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      score = vals[i];
      repeat (14) @(posedge clk);
      #1;
      n_cmp++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL values_valid[%0d]: got %b want 1", i, bcd_valid); end
      n_cmp++; if (bcd !== exps[i]) begin n_fail++; $display("FAIL values_bcd[%0d]: got %h want %h", i, bcd, exps[i]); end
    end
  endtask

  task automatic test_scan;
    logic [11:0] vals [2];
    logic [27:0] segs [2];
    logic [3:0]  prev;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    bit          found;
    int          d;
    vals = '{12'd7, 12'd1005};
    segs = '{{7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h79, 7'h40, 7'h40, 7'h12}};
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      score = vals[s];
      repeat (20) @(posedge clk);
      #1;
      found = 1'b0;
      prev  = an;
      for (int t = 0; t < 40 && !found; t++) begin
        @(posedge clk); #1;
        if (an === 4'hE && prev !== 4'hE) found = 1'b1;
        else prev = an;
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL scan_sync[%0d]: got no E entry want E within 40 cycles", s); end
      for (int i = 0; i < 20; i++) begin
        d = (i / 4) % 4;
        exp_an  = ~(4'b0001 << d);
        exp_seg = segs[s][d*7 +: 7];
        n_cmp++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an[%0d][%0d]: got %h want %h", s, i, an, exp_an); end
        n_cmp++; if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg[%0d][%0d]: got %h want %h", s, i, seg, exp_seg); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    pulses = 0;
    score = 12'd10;
    repeat (5) @(posedge clk);
    #1;
    score = 12'd11;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid: got %b want 0", bcd_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", bcd_valid); end
    n_cmp++; if (bcd !== 16'h0010) begin n_fail++; $display("FAIL b2b_first_bcd: got %h want 0010", bcd); end
    repeat (13) @(posedge clk);
    #1;
    n_cmp++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_mid_valid: got %b want 0", bcd_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", bcd_valid); end
    n_cmp++; if (bcd !== 16'h0011) begin n_fail++; $display("FAIL b2b_second_bcd: got %h want 0011", bcd); end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 2", pulses); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    pulses = 0;
    score = 12'd3000;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_bcd: got %h want 0000", bcd); end
    n_cmp++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bcd_valid); end
    n_cmp++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL midrst_seg: got %h want 7F", seg); end
    n_cmp++; if (an !== 4'hF) begin n_fail++; $display("FAIL midrst_an: got %h want F", an); end
    score = 12'd42;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    n_cmp++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early_valid: got %b want 0", bcd_valid); end
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_early_bcd: got %h want 0000", bcd); end
    @(posedge clk); #1;
    n_cmp++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid_after: got %b want 1", bcd_valid); end
    n_cmp++; if (bcd !== 16'h0042) begin n_fail++; $display("FAIL midrst_bcd_after: got %h want 0042", bcd); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL midrst_pulse_count: got %0d want 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
